// File: rtl/nes_pkg.sv
`default_nettype none
// ==========================================================================
// nes_pkg : shared button indices, FSM states and publish helper for the
//           NES controller reader.                       Revision: 1.0
// ==========================================================================
package nes_pkg;

  localparam int NES_NUM_BUTTONS = 8;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  typedef logic [NES_NUM_BUTTONS-1:0] nes_buttons_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } nes_state_e;

  // An all-zero frame means the data line is grounded: report nothing pressed.
  function automatic nes_buttons_t nes_publish(input nes_buttons_t raw);
    return (raw != '0) ? ~raw : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nes_if.sv
`default_nettype none
// ==========================================================================
// nes_if : controller serial lines plus the published button levels.
//                                                        Revision: 1.0
// ==========================================================================
interface nes_if;
  import nes_pkg::*;

  logic io_data;
  logic io_latch;
  logic io_pulse;
  logic io_a;
  logic io_b;
  logic io_select;
  logic io_start;
  logic io_up;
  logic io_down;
  logic io_left;
  logic io_right;
  logic io_connected;
  logic io_valid;

  modport master (
    input  io_data,
    output io_latch, io_pulse,
    output io_a, io_b, io_select, io_start,
    output io_up, io_down, io_left, io_right,
    output io_connected, io_valid
  );

  modport slave (
    output io_data,
    input  io_latch, io_pulse,
    input  io_a, io_b, io_select, io_start,
    input  io_up, io_down, io_left, io_right,
    input  io_connected, io_valid
  );

endinterface
`default_nettype wire

// File: rtl/nes_reader_tick_gen.sv
`default_nettype none
// ==========================================================================
// nes_tick_gen : free-running protocol tick prescaler and poll-rate counter.
//                                                        Revision: 1.0
// ==========================================================================
module nes_tick_gen
  import nes_pkg::*;
#(
  parameter int TICK_CYCLES = 445,
  parameter int POLL_TICKS  = 2778
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o,
  output logic poll_start_o
);

  localparam int PRE_W  = $clog2(TICK_CYCLES);
  localparam int POLL_W = $clog2(POLL_TICKS);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);

  logic [PRE_W-1:0]  pre_q;
  logic [POLL_W-1:0] poll_q;

  assign tick_o       = (pre_q == PRE_LAST);
  assign poll_start_o = tick_o && (poll_q == POLL_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pre_q  <= '0;
      poll_q <= '0;
    end else begin
      pre_q <= tick_o ? '0 : pre_q + 1'b1;
      if (tick_o) begin
        poll_q <= poll_start_o ? '0 : poll_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nes_reader.sv
`default_nettype none
// ==========================================================================
// nes_reader : polls an NES pad over latch/pulse/data and publishes held,
//              active-high button levels once per frame. Revision: 1.0
// ==========================================================================
module nes_reader
  import nes_pkg::*;
#(
  parameter int TICK_CYCLES = 445,
  parameter int POLL_TICKS  = 2778
) (
  input  logic  clock,
  input  logic  reset,
  nes_if.master bus
);

  logic tick;
  logic poll_start;

  nes_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES),
    .POLL_TICKS  (POLL_TICKS)
  ) u_tick_gen (
    .clock_i      (clock),
    .reset_i      (reset),
    .tick_o       (tick),
    .poll_start_o (poll_start)
  );

  // Idle level of the line is high, so the synchronizer resets to 1.
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.io_data;
      sync2_q <= sync1_q;
    end
  end

  nes_state_e   state_q;
  logic         latch_q;
  logic         pulse_q;
  logic         latch_tick_q;
  logic [2:0]   bit_idx_q;
  nes_buttons_t shift_q;
  nes_buttons_t shift_d;
  nes_buttons_t buttons_q;
  logic         connected_q;
  logic         valid_q;

  always_comb begin
    shift_d            = shift_q;
    shift_d[bit_idx_q] = sync2_q;
  end

  // The final bit is folded in via shift_d so buttons, connected and valid
  // all become visible together in the DONE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      latch_q      <= 1'b0;
      pulse_q      <= 1'b0;
      latch_tick_q <= 1'b0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'hFF;
      buttons_q    <= '0;
      connected_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (poll_start) begin
            state_q      <= LATCH;
            latch_q      <= 1'b1;
            latch_tick_q <= 1'b0;
            bit_idx_q    <= 3'd0;
          end
        end
        LATCH: begin
          if (tick) begin
            if (latch_tick_q) begin
              state_q <= LOW;
              latch_q <= 1'b0;
            end else begin
              latch_tick_q <= 1'b1;
            end
          end
        end
        LOW: begin
          if (tick) begin
            shift_q <= shift_d;
            if (bit_idx_q == 3'd7) begin
              state_q     <= DONE;
              valid_q     <= 1'b1;
              connected_q <= (shift_d != '0);
              buttons_q   <= nes_publish(shift_d);
            end else begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (tick) begin
            state_q   <= LOW;
            pulse_q   <= 1'b0;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          latch_q <= 1'b0;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_latch     = latch_q;
  assign bus.io_pulse     = pulse_q;
  assign bus.io_connected = connected_q;
  assign bus.io_valid     = valid_q;
  assign bus.io_a         = buttons_q[NES_A];
  assign bus.io_b         = buttons_q[NES_B];
  assign bus.io_select    = buttons_q[NES_SELECT];
  assign bus.io_start     = buttons_q[NES_START];
  assign bus.io_up        = buttons_q[NES_UP];
  assign bus.io_down      = buttons_q[NES_DOWN];
  assign bus.io_left      = buttons_q[NES_LEFT];
  assign bus.io_right     = buttons_q[NES_RIGHT];

endmodule
`default_nettype wire

// File: tb/tb_nes_reader.sv
`default_nettype none
// ==========================================================================
// tb_nes_reader : directed + randomized bench with a behavioural NES pad.
//                                                        Revision: 1.0
// ==========================================================================
module tb_nes_reader;
  import nes_pkg::*;

  localparam int TICK_CYCLES = 4;
  localparam int POLL_TICKS  = 20;
  localparam int T           = TICK_CYCLES;
  localparam int POLL_CYC    = TICK_CYCLES * POLL_TICKS;
  localparam int VALID_OFS   = 17 * TICK_CYCLES;

  logic clock = 1'b0;
  logic reset = 1'b1;

  nes_if bus ();

  nes_reader #(
    .TICK_CYCLES (TICK_CYCLES),
    .POLL_TICKS  (POLL_TICKS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Cycle number since the last reset release, as seen at the negedge.
  int cyc = 0;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Pad model: presents bit0 while latched, advances on each rising pulse.
  logic [7:0] pad_raw    = 8'hFF;
  int         pad_idx    = 0;
  logic       pad_data   = 1'b1;
  logic       prev_pulse = 1'b0;
  logic       ovr_en     = 1'b1;
  logic       ovr_data   = 1'b1;

  always @(negedge clock) begin
    if (bus.io_latch) pad_idx = 0;
    else if (bus.io_pulse && !prev_pulse) pad_idx = pad_idx + 1;
    prev_pulse = bus.io_pulse;
    pad_data   = (pad_idx < 8) ? pad_raw[pad_idx] : 1'b1;
  end

  assign bus.io_data = ovr_en ? ovr_data : pad_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {connected, buttons} expected from the raw active-low frame.
  function automatic logic [8:0] expect_pub(input logic [7:0] raw);
    if (raw == 8'h00) return 9'h000;
    return {1'b1, ~raw};
  endfunction

  function automatic logic [8:0] dut_outs();
    return {bus.io_connected, bus.io_right, bus.io_left, bus.io_down, bus.io_up,
            bus.io_start, bus.io_select, bus.io_b, bus.io_a};
  endfunction

  task automatic wait_valid(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 3 * POLL_CYC && at < 0; i++) begin
      @(negedge clock);
      if (bus.io_valid) at = cyc;
    end
    check({tag, " valid seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 4 * POLL_CYC && cyc != target; i++) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   v;
    int   p;
    int   off;
    int   latch_err;
    int   pulse_err;
    int   both_hi;
    int   n_valid;
    int   valid_at;
    int   first_latch;
    int   hold_err;
    logic exp_latch;
    logic exp_pulse;
    logic [8:0] held;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset latch", 32'(bus.io_latch), 32'd0);
    check("reset pulse", 32'(bus.io_pulse), 32'd0);
    check("reset valid", 32'(bus.io_valid), 32'd0);
    check("reset outs",  32'(dut_outs()),   32'd0);

    // Timing with line held high: this negedge is cycle 0 after release
    reset = 1'b0;
    latch_err = 0; pulse_err = 0; both_hi = 0; n_valid = 0; valid_at = -1; first_latch = -1;
    for (int i = 1; i < 2 * POLL_CYC; i++) begin
      @(negedge clock);
      off       = cyc - POLL_CYC;
      exp_latch = (off >= 0) && (off < 2 * T);
      off       = cyc - POLL_CYC - 3 * T;
      exp_pulse = (off >= 0) && (off < 14 * T) && ((off % (2 * T)) < T);
      if (bus.io_latch !== exp_latch) latch_err++;
      if (bus.io_pulse !== exp_pulse) pulse_err++;
      if (bus.io_latch && bus.io_pulse) both_hi++;
      if (bus.io_latch && first_latch < 0) first_latch = cyc;
      if (bus.io_valid) begin n_valid++; valid_at = cyc; end
    end
    check("timing first latch",    32'(first_latch), 32'(POLL_CYC));
    check("timing latch waveform", 32'(latch_err),   32'd0);
    check("timing pulse waveform", 32'(pulse_err),   32'd0);
    check("timing latch&pulse",    32'(both_hi),     32'd0);
    check("timing valid count",    32'(n_valid),     32'd1);
    check("timing valid cycle",    32'(valid_at),    32'(POLL_CYC + VALID_OFS));
    check("timing pull-up outs",   32'(dut_outs()),  32'(expect_pub(8'hFF)));

    // Fixed button pattern from the pad model
    ovr_en  = 1'b0;
    pad_raw = 8'b1010_1110;
    wait_valid("pattern", v);
    check("pattern valid cycle", 32'(v), 32'(2 * POLL_CYC + VALID_OFS));
    @(negedge clock);
    check("pattern valid width", 32'(bus.io_valid), 32'd0);
    check("pattern A",      32'(bus.io_a),      32'd1);
    check("pattern B",      32'(bus.io_b),      32'd0);
    check("pattern Up",     32'(bus.io_up),     32'd1);
    check("pattern Left",   32'(bus.io_left),   32'd1);
    check("pattern Right",  32'(bus.io_right),  32'd0);
    check("pattern vector", 32'(dut_outs()),    32'h151);

    // Random patterns
    for (int r = 0; r < 5; r++) begin
      pad_raw = 8'($urandom);
      wait_valid("random", v);
      @(negedge clock);
      check("random outs", 32'(dut_outs()), 32'(expect_pub(pad_raw)));
    end

    // Grounded / pull-down line
    pad_raw = 8'h00;
    wait_valid("disconnected", v);
    @(negedge clock);
    check("disconnected outs", 32'(dut_outs()), 32'd0);

    // Hold between polls while the line wiggles in IDLE
    pad_raw = 8'h5A;
    wait_valid("hold setup", v);
    @(negedge clock);
    check("hold setup outs", 32'(dut_outs()), 32'(expect_pub(8'h5A)));
    held     = dut_outs();
    hold_err = 0;
    ovr_en   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      ovr_data = 1'($urandom);
      if (dut_outs() !== held || bus.io_valid) hold_err++;
    end
    ovr_en  = 1'b0;
    pad_raw = 8'hC3;
    v       = -1;
    for (int i = 0; i < 3 * POLL_CYC && v < 0; i++) begin
      @(negedge clock);
      if (bus.io_valid) v = cyc;
      else if (dut_outs() !== held) hold_err++;
    end
    check("hold outputs stable", 32'(hold_err), 32'd0);
    check("hold next valid",     32'(v >= 0),   32'd1);
    @(negedge clock);
    check("hold new outs", 32'(dut_outs()), 32'(expect_pub(8'hC3)));

    // Synchronizer delay: bit2 edge 1 cycle early is missed, bit3 edge 2 early is seen
    p        = v - VALID_OFS + POLL_CYC;
    ovr_en   = 1'b1;
    ovr_data = 1'b1;
    wait_cyc(p + 3 * T - 1 + 2 * T * 2 - 1);
    ovr_data = 1'b0;
    wait_cyc(p + 3 * T - 1 + 2 * T * 3 + 1);
    ovr_data = 1'b1;
    wait_valid("sync", v);
    @(negedge clock);
    check("sync select", 32'(bus.io_select), 32'd0);
    check("sync start",  32'(bus.io_start),  32'd1);
    check("sync outs",   32'(dut_outs()),    32'(expect_pub(8'b1111_0111)));

    // Reset during the 4th HIGH tick
    p       = v - VALID_OFS + POLL_CYC;
    ovr_en  = 1'b0;
    pad_raw = 8'h7E;
    wait_cyc(p + 3 * T + 2 * T * 3 + 1);
    check("midreset pulse before", 32'(bus.io_pulse), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset pulse", 32'(bus.io_pulse), 32'd0);
    check("midreset latch", 32'(bus.io_latch), 32'd0);
    check("midreset valid", 32'(bus.io_valid), 32'd0);
    check("midreset outs",  32'(dut_outs()),   32'd0);
    n_valid = 0; valid_at = -1; first_latch = -1;
    for (int i = 1; i < 2 * POLL_CYC; i++) begin
      @(negedge clock);
      if (bus.io_latch && first_latch < 0) first_latch = cyc;
      if (bus.io_valid) begin n_valid++; valid_at = cyc; end
    end
    check("midreset first latch", 32'(first_latch), 32'(POLL_CYC));
    check("midreset valid count", 32'(n_valid),     32'd1);
    check("midreset valid cycle", 32'(valid_at),    32'(POLL_CYC + VALID_OFS));
    check("midreset outs after",  32'(dut_outs()),  32'(expect_pub(8'h7E)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
